// File: rtl/cla_adder.sv
// cla_adder: registered two's-complement adder with carry-in on a
// hierarchical carry-lookahead network. It produces the sum, the unsigned
// carry-out and the signed-overflow flag.
//
// Structure:
//   level 1 - per-bit generate/propagate, 4-bit groups with fully expanded
//             in-group carries and group G/P
//   level 2 - lookahead over group G/P; every group carry-in is a flat
//             sum-of-products of Cin and the group terms (no ripple)
//   level 3 - only when WIDTH/4 > 8: groups are bundled into blocks of 8.
//             Block G/P feed a top lookahead that produces the block
//             carry-ins, and level 2 then works inside each block.
//
// Optional feature: define CLA_INPUT_REG_EN to register a, b and Cin
// (reset value 0) in front of the lookahead network. Latency then goes from
// 1 to 2 cycles and throughput stays at one operand set per cycle.
//
// Flow control: there is no handshake. An operand set is taken on every
// rising clk edge while rst_n is high. Its result is valid on the outputs
// 1 cycle later (2 cycles with CLA_INPUT_REG_EN) and never stalls.
//
// WIDTH must be a multiple of 4.

module cla_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             Cin,
  output logic [WIDTH-1:0] sum,
  output logic             Cout,
  output logic             of
);

  localparam int NG  = WIDTH / 4;              // number of 4-bit groups
  localparam int GPB = 8;                      // groups per third-level block
  localparam int NB  = (NG + GPB - 1) / GPB;   // number of third-level blocks

  // ---------------------------------------------------------------------------
  // Operand stage
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             cin_i;

`ifdef CLA_INPUT_REG_EN
  // Capture the operands so the lookahead network starts from a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_i   <= '0;
      b_i   <= '0;
      cin_i <= 1'b0;
    end else begin
      a_i   <= a;
      b_i   <= b;
      cin_i <= Cin;
    end
  end
`else
  assign a_i   = a;
  assign b_i   = b;
  assign cin_i = Cin;
`endif

  // ---------------------------------------------------------------------------
  // Lookahead helpers (pure AND/OR; loops unroll to flat product terms)
  // ---------------------------------------------------------------------------

  // AND of pv[lo..hi]. An empty range (lo > hi) gives 1.
  function automatic logic and_range(input logic [NG-1:0] pv,
                                     input int lo, input int hi);
    logic r;
    r = 1'b1;
    for (int m = 0; m < NG; m++) begin
      if (m >= lo && m <= hi) r = r & pv[m];
    end
    return r;
  endfunction

  // Carry out of items lo..hi with carry-in ci entering item lo:
  //   ci & P[lo..hi]  |  OR over k of  G[k] & P[k+1..hi]
  // Written as a flat sum of products, so nothing ripples.
  function automatic logic lookahead(input logic [NG-1:0] gv,
                                     input logic [NG-1:0] pv,
                                     input logic ci,
                                     input int lo, input int hi);
    logic r;
    r = ci & and_range(pv, lo, hi);
    for (int k = 0; k < NG; k++) begin
      if (k >= lo && k <= hi) r = r | (gv[k] & and_range(pv, k + 1, hi));
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Level 1: bit generate/propagate and 4-bit groups
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [NG-1:0]    grp_g;
  logic [NG-1:0]    grp_p;
  logic [NG:0]      grp_c;     // grp_c[k] = carry into group k; grp_c[NG] = carry out
  logic [WIDTH:0]   c;         // c[i] = carry into bit i; c[WIDTH] = carry out

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  genvar gk;
  for (gk = 0; gk < NG; gk++) begin : g_group
    localparam int B = 4 * gk;

    assign grp_g[gk] = g[B+3]
                     | (p[B+3] & g[B+2])
                     | (p[B+3] & p[B+2] & g[B+1])
                     | (p[B+3] & p[B+2] & p[B+1] & g[B]);
    assign grp_p[gk] = p[B+3] & p[B+2] & p[B+1] & p[B];

    // In-group carries, fully expanded from the group carry-in.
    assign c[B]   = grp_c[gk];
    assign c[B+1] = g[B]
                  | (p[B] & grp_c[gk]);
    assign c[B+2] = g[B+1]
                  | (p[B+1] & g[B])
                  | (p[B+1] & p[B] & grp_c[gk]);
    assign c[B+3] = g[B+2]
                  | (p[B+2] & g[B+1])
                  | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & grp_c[gk]);
  end

  // The carry out of the top bit comes straight from the lookahead network.
  assign c[WIDTH] = grp_c[NG];

  // ---------------------------------------------------------------------------
  // Levels 2 and 3: group carry-ins
  // ---------------------------------------------------------------------------
  if (NG <= GPB) begin : g_two_level
    // Every group carry-in is computed directly from Cin and the group G/P.
    always_comb begin
      grp_c    = '0;
      grp_c[0] = cin_i;
      for (int j = 0; j < NG; j++) begin
        grp_c[j+1] = lookahead(grp_g, grp_p, cin_i, 0, j);
      end
    end
  end else begin : g_three_level
    logic [NB-1:0] blk_g;
    logic [NB-1:0] blk_p;
    logic [NB-1:0] blk_c;     // carry into each block of GPB groups
    logic [NG-1:0] blk_g_ext;
    logic [NG-1:0] blk_p_ext;

    // Block generate/propagate, each taken over its own groups.
    always_comb begin
      blk_g = '0;
      blk_p = '0;
      for (int s = 0; s < NB; s++) begin
        blk_g[s] = lookahead(grp_g, grp_p, 1'b0, s * GPB,
                             (s * GPB + GPB - 1 < NG) ? s * GPB + GPB - 1 : NG - 1);
        blk_p[s] = and_range(grp_p, s * GPB,
                             (s * GPB + GPB - 1 < NG) ? s * GPB + GPB - 1 : NG - 1);
      end
    end

    // Top lookahead: block carry-ins come flat from Cin and the block G/P.
    always_comb begin
      blk_g_ext          = '0;
      blk_p_ext          = '0;
      blk_g_ext[NB-1:0]  = blk_g;
      blk_p_ext[NB-1:0]  = blk_p;
      blk_c              = '0;
      blk_c[0]           = cin_i;
      for (int s = 1; s < NB; s++) begin
        blk_c[s] = lookahead(blk_g_ext, blk_p_ext, cin_i, 0, s - 1);
      end
    end

    // Second level inside each block, seeded by that block's carry-in.
    always_comb begin
      grp_c    = '0;
      grp_c[0] = cin_i;
      for (int j = 0; j < NG; j++) begin
        grp_c[j+1] = lookahead(grp_g, grp_p, blk_c[j / GPB], (j / GPB) * GPB, j);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sum, flags and output register
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             of_d;

  assign sum_d  = p ^ c[WIDTH-1:0];
  assign cout_d = c[WIDTH];
  assign of_d   = c[WIDTH] ^ c[WIDTH-1];

  // Register the result. Reset clears it at once and drops in-flight data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      Cout <= 1'b0;
      of   <= 1'b0;
    end else begin
      sum  <= sum_d;
      Cout <= cout_d;
      of   <= of_d;
    end
  end

endmodule

// File: tb/tb_cla_adder.sv
// tb_cla_adder: table-driven and random checks of cla_adder. Expected
// {Cout, of, sum} records are queued when operands are driven. They are
// popped when the result is due at the DUT output.

module tb_cla_adder;

  localparam int W = 32;
`ifdef CLA_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [W-1:0] sum;
  logic         cout;
  logic         of;

  always #5 clk = ~clk;

  cla_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .b    (b),
    .Cin  (cin),
    .sum  (sum),
    .Cout (cout),
    .of   (of)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [W+1:0] exp_q[$];     // {Cout, of, sum}
  logic         valid_in = 1'b0;
  logic [1:0]   vpipe = '0;
  int           total = 0;
  int           bad = 0;

  task automatic check(input string name, input logic [W+1:0] act,
                       input logic [W+1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got cout=%b of=%b sum=%h, expected cout=%b of=%b sum=%h",
               name, act[W+1], act[W], act[W-1:0], exp[W+1], exp[W], exp[W-1:0]);
    end
  endtask

  // Reference: 33-bit sum, with of taken from the operand/result sign rule.
  function automatic logic [W+1:0] ref_model(input logic [W-1:0] ra,
                                             input logic [W-1:0] rb,
                                             input logic rc);
    logic [W:0] s;
    logic       ov;
    s  = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
    ov = (ra[W-1] == rb[W-1]) && (s[W-1] != ra[W-1]);
    return {s[W], ov, s[W-1:0]};
  endfunction

  // Monitor: track which edges carry a valid operand set and compare the
  // result once it has gone through the pipeline.
  always @(posedge clk) begin
    if (!rst_n) vpipe = '0;
    else        vpipe = {vpipe[0], valid_in};
    #1;
    if (vpipe[LAT-1]) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL result: output valid with empty expected queue (sum=%h)", sum);
      end else begin
        check("result", {cout, of, sum}, exp_q.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                       input logic tc, input logic [W+1:0] e);
    @(negedge clk);
    a        = ta;
    b        = tb_;
    cin      = tc;
    valid_in = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      valid_in = 1'b0;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vc;
    logic [W-1:0] es;
    logic         eco;
    logic         eov;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b1};
    tbl[1] = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1};
    tbl[2] = '{32'h12345678, 32'h80000000, 1'b0, 32'h92345678, 1'b0, 1'b0};
    tbl[3] = '{32'hFFFFF999, 32'h00000111, 1'b0, 32'hFFFFFAAA, 1'b0, 1'b0};
    tbl[4] = '{32'h12345678, 32'h12345670, 1'b1, 32'h2468ACE9, 1'b0, 1'b0};
    tbl[5] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
    tbl[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0};
    tbl[7] = '{32'h00000420, 32'h00000420, 1'b1, 32'h00000841, 1'b0, 1'b0};
    tbl[8] = '{32'h00000123, 32'h00000123, 1'b0, 32'h00000246, 1'b0, 1'b0};

    // ---- reset state: outputs 0 with no clock edge yet ----
    rst_n = 1'b0;
    a     = $urandom();
    b     = $urandom();
    cin   = 1'b1;
    #1;
    check("reset_initial", {cout, of, sum}, '0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold_edges", {cout, of, sum}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- table vectors, back-to-back, one per cycle ----
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].va, tbl[i].vb, tbl[i].vc, {tbl[i].eco, tbl[i].eov, tbl[i].es});
    end
    idle(LAT + 2);

    // ---- asynchronous reset mid-stream ----
    drive(32'h0F0F0F0F, 32'h01010101, 1'b0, ref_model(32'h0F0F0F0F, 32'h01010101, 1'b0));
    idle(LAT + 1);
    check("pre_reset_value", {cout, of, sum}, {2'b00, 32'h10101010});
    drive(32'hDEADBEEF, 32'h11111111, 1'b1, ref_model(32'hDEADBEEF, 32'h11111111, 1'b1));
    #2;
    rst_n    = 1'b0;
    valid_in = 1'b0;
    exp_q.delete();
    #1;
    check("reset_async", {cout, of, sum}, '0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_midstream_hold", {cout, of, sum}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- first results after reset release, back-to-back ----
    drive(32'h80000000, 32'h80000000, 1'b0, ref_model(32'h80000000, 32'h80000000, 1'b0));
    drive(32'h00000001, 32'hFFFFFFFF, 1'b0, ref_model(32'h00000001, 32'hFFFFFFFF, 1'b0));
    drive(32'h7FFFFFFF, 32'h00000000, 1'b1, ref_model(32'h7FFFFFFF, 32'h00000000, 1'b1));
    idle(LAT + 2);

    // ---- random operands ----
    for (int i = 0; i < 10000; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;
      ra = $urandom();
      rb = $urandom();
      rc = 1'($urandom_range(0, 1));
      if (i % 50 == 0) rb = ~ra;    // long propagate chains
      drive(ra, rb, rc, ref_model(ra, rb, rc));
    end
    idle(LAT + 3);

    // ---- every expected result must have been consumed ----
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d results still expected, required 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
